// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-requester RAM port arbiter.
package mem_port_arbiter_pkg;
    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 16;
    localparam int CNT_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;
endpackage

// File: rtl/mem_port_arbiter_mux16.sv
// Gate-level 2:1 mux, W bits with a common select (16 by default, trimmed for addresses).
module mux16 #(
    parameter int W = 16
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    logic nsel;

    not u_inv (nsel, sel);

    for (genvar i = 0; i < W; i++) begin : g_bit
        logic ta, tb;
        and u_a (ta, a[i], nsel);
        and u_b (tb, b[i], sel);
        or  u_o (y[i], ta, tb);
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported RAM between the CPU data port (0)
// and the UART loader (1); single-beat req/ack transactions.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [ADDR_W-1:0]  addr_mux;
    logic [DATA_W-1:0]  wdata_mux;
    logic               we_sel, in_access, ack, rd_done;

    mux16 #(.W(DATA_W)) u_wdata_mux (.sel(owner_q), .a(wdata0), .b(wdata1), .y(wdata_mux));
    mux16 #(.W(ADDR_W)) u_addr_mux  (.sel(owner_q), .a(addr0),  .b(addr1),  .y(addr_mux));

    assign we_sel    = owner_q ? we1 : we0;
    assign in_access = (state_q == ST_ACCESS);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ack     = 1'b0;
        rd_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    owner_d = (req0 && req1) ? ~last_q : req1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (we_sel) begin
                    ack     = 1'b1;
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end else if (RD_LAT == 1) begin
                    ack     = 1'b1;
                    rd_done = 1'b1;
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The cycle whose decrement reaches zero is the ack cycle.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    ack     = 1'b1;
                    rd_done = 1'b1;
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shared port follows the mux only while ACCESS; otherwise it holds the last address/data.
    always_comb begin
        addr_d  = in_access ? addr_mux  : addr_q;
        wdata_d = in_access ? wdata_mux : wdata_q;
        rdata_d = rd_done   ? mem_rdata : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign ack0      = ack & ~owner_q;
    assign ack1      = ack &  owner_q;
    assign mem_we    = in_access & we_sel;
    assign mem_addr  = in_access ? addr_mux  : addr_q;
    assign mem_wdata = in_access ? wdata_mux : wdata_q;
    assign rdata     = rd_done   ? mem_rdata : rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expected transactions, a
// negedge monitor pops them on every ack and checks against a behavioural RAM/arbiter model.
module tb_mem_port_arbiter;
    localparam int AW     = 15;
    localparam int DW     = 16;
    localparam int RD_LAT = 2;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, mem_we;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata, rd_pipe;
    logic [AW-1:0] mem_addr;

    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, last_served = 1, ack0_cnt = 0, we_cnt = 0;
    txn_t exp_q0[$];
    txn_t exp_q1[$];
    int   order_q[$];
    logic [1:0]    hist [0:15];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] ram    [0:(1<<AW)-1];
    bit            ram_wr [0:(1<<AW)-1];

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return DW'({1'b0, a}) ^ 16'hA5C3;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // RAM with RD_LAT-1 register stages after the address (RD_LAT=2: one stage).
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]    <= mem_wdata;
            ram_wr[mem_addr] <= 1'b1;
        end
        rd_pipe <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
    end
    assign mem_rdata = rd_pipe;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_q0.delete();
            exp_q1.delete();
            order_q.delete();
            last_served = 1;
        end else begin
            txn_t t;
            int   p, gexp, ok;
            logic [1:0] h;
            cyc++;
            hist[cyc & 15] = {req1, req0};
            if (mem_we) begin
                we_cnt++;
                chk("we_only_with_write_ack", int'(ack0 | ack1), 1);
            end
            if (ack0 || ack1) begin
                chk("ack_exclusive", int'(ack0 & ack1), 0);
                p  = ack1 ? 1 : 0;
                ok = (p == 0) ? int'(exp_q0.size() != 0) : int'(exp_q1.size() != 0);
                chk("ack_has_request", ok, 1);
                if (ok != 0) begin
                    t = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    chk("ack_we", int'(mem_we), int'(t.we));
                    chk("ack_addr", int'(mem_addr), int'(t.addr));
                    if (t.we) begin
                        chk("ram_wdata", int'(mem_wdata), int'(t.wdata));
                        ref_mem[t.addr] = t.wdata;
                    end else begin
                        chk("read_data", int'(rdata), int'(ref_rd(t.addr)));
                    end
                    // Requests seen in the IDLE cycle just before ACCESS decide the grant.
                    h = hist[(cyc - (t.we ? 1 : RD_LAT)) & 15];
                    gexp = (h == 2'b11) ? 1 - last_served : (h == 2'b01) ? 0 : (h == 2'b10) ? 1 : 2;
                    chk("grant_owner", p, gexp);
                    last_served = p;
                    order_q.push_back(p);
                    if (p == 0) ack0_cnt++;
                end
            end
        end
    end

    task automatic txn(input int p, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int lat);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        @(posedge clk); #1;
        if (p == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; exp_q0.push_back(t);
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; exp_q1.push_back(t);
        end
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rst) break;
            if ((p == 0 && ack0) || (p == 1 && ack1)) begin
                lat = i;
                break;
            end
        end
        if (!rst) chk("ack_seen", int'(lat >= 0), 1);
    endtask

    task automatic drop(input int p, input int n);
        @(posedge clk); #1;
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int lat, w, c0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack0", int'(ack0), 0);
        chk("rst_ack1", int'(ack1), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_rdata", int'(rdata), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single write, then single read of the same word from the other port
        txn(0, 1'b1, 15'h0010, 16'hBEEF, lat);
        chk("t1_write_latency", lat, 1);
        drop(0, 1);
        w = we_cnt;
        txn(1, 1'b0, 15'h0010, 16'h0000, lat);
        chk("t2_read_latency", lat, RD_LAT);
        chk("t2_rdata", int'(rdata), 16'hBEEF);
        drop(1, 1);
        chk("t2_no_we_during_read", we_cnt, w);

        // Contention from reset: grants alternate starting with port 0
        do_reset();
        fork
            begin
                for (int i = 0; i < 4; i++) txn(0, 1'b1, AW'(32 + i), DW'(16'h1000 + i), lat);
                drop(0, 1);
            end
            begin
                for (int i = 0; i < 4; i++) txn(1, 1'b1, AW'(48 + i), DW'(16'h2000 + i), lat);
                drop(1, 1);
            end
        join
        chk("t3_ack_count", order_q.size(), 8);
        for (int i = 0; i < 8 && i < order_q.size(); i++) chk("t3_alternation", order_q[i], i & 1);

        // Fairness: port 0 streams, port 1 asks once
        fork
            begin
                for (int i = 0; i < 6; i++)
                    txn(0, 1'(i & 1), AW'(32 + (i >> 1)), DW'($urandom), lat);
                drop(0, 1);
            end
            begin
                int lat1;
                repeat (3) @(posedge clk);
                c0 = ack0_cnt;
                txn(1, 1'b0, 15'h0033, 16'h0000, lat1);
                chk("t4_port1_waits_at_most_one", int'(ack0_cnt - c0 <= 1), 1);
                drop(1, 1);
            end
        join

        // Reset in the middle of a read, then in the middle of a write
        do_reset();
        @(posedge clk); #1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 15'h0010;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("t5_rd_ack1", int'(ack1), 0);
        chk("t5_rd_mem_addr", int'(mem_addr), 0);
        chk("t5_rd_rdata", int'(rdata), 0);
        req1 = 1'b0;
        @(negedge clk);
        chk("t5_rd_no_ack", int'(ack0 | ack1), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 15'h0055; wdata0 = 16'h1234;
        @(posedge clk); #2;
        chk("t5_wr_we_before", int'(mem_we), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_wr_we_drops", int'(mem_we), 0);
        chk("t5_wr_mem_wdata", int'(mem_wdata), 0);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fork
            begin txn(0, 1'b0, 15'h0055, 16'h0000, lat); drop(0, 1); end
            begin txn(1, 1'b0, 15'h0010, 16'h0000, lat); drop(1, 1); end
        join
        chk("t5_first_grant_port0", (order_q.size() > 0) ? order_q[0] : -1, 0);

        // Random traffic on both ports
        w = cyc;
        fork
            begin
                int l0;
                while (cyc < w + 1000) begin
                    int g = $urandom_range(0, 2);
                    if (g != 0) drop(0, g);
                    txn(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom), l0);
                end
                drop(0, 1);
            end
            begin
                int l1;
                while (cyc < w + 1000) begin
                    int g = $urandom_range(0, 2);
                    if (g != 0) drop(1, g);
                    txn(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom), l1);
                end
                drop(1, 1);
            end
        join
        repeat (4) @(negedge clk);
        chk("t6_q0_drained", exp_q0.size(), 0);
        chk("t6_q1_drained", exp_q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
